// File: rtl/instr_mem_loader_if.sv
// Host-side bundle for instr_mem_loader: beat-serial loader, fetch port and status.
// INSTR_MEM_PARITY_EN adds perr_inject / parity_err.
interface instr_mem_loader_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Lanes     = 4,
    parameter int unsigned AddrWidth = 10
);
    logic                         load_valid;
    logic                         load_ready;
    logic [DataWidth-1:0]         load_data;
    logic                         load_last;
    logic [AddrWidth-1:0]         load_base;
    logic                         fetch_req;
    logic [AddrWidth-1:0]         fetch_pc;
    logic [DataWidth*Lanes-1:0]   instr;
    logic                         instr_valid;
    logic                         busy;
    logic                         load_done;
    logic [AddrWidth:0]           load_count;
`ifdef INSTR_MEM_PARITY_EN
    logic                         perr_inject;
    logic                         parity_err;
`endif

    modport master (
        output load_valid, load_data, load_last, load_base, fetch_req, fetch_pc,
        input  load_ready, instr, instr_valid, busy, load_done, load_count
`ifdef INSTR_MEM_PARITY_EN
        , output perr_inject, input parity_err
`endif
    );

    modport slave (
        input  load_valid, load_data, load_last, load_base, fetch_req, fetch_pc,
        output load_ready, instr, instr_valid, busy, load_done, load_count
`ifdef INSTR_MEM_PARITY_EN
        , input perr_inject, output parity_err
`endif
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with sequential clear, beat-serial program loader and registered fetch.
// Optional per-word even parity when INSTR_MEM_PARITY_EN is defined.
module instr_mem_loader #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Lanes     = 4,
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned Depth     = 1024
) (
    input  logic                clk,
    input  logic                rstn,
    instr_mem_loader_if.slave   bus
);
    localparam int unsigned IW  = DataWidth * Lanes;
    localparam int unsigned LCW = (Lanes > 1) ? $clog2(Lanes) : 1;
`ifdef INSTR_MEM_PARITY_EN
    localparam int unsigned MW  = IW + 1;
`else
    localparam int unsigned MW  = IW;
`endif
    localparam logic [AddrWidth:0]   DEPTH_W   = (AddrWidth+1)'(Depth);
    localparam logic [AddrWidth-1:0] LAST_ADDR = AddrWidth'(Depth - 1);
    localparam logic [LCW-1:0]       LAST_LANE = LCW'(Lanes - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] clr_ptr_q, clr_ptr_d;
    logic [AddrWidth-1:0] wptr_q, wptr_d;
    logic [LCW-1:0]       lane_cnt_q, lane_cnt_d;
    logic [IW-1:0]        buf_q, buf_d;
    logic                 load_done_q, load_done_d;
    logic [AddrWidth:0]   load_count_q, load_count_d;
    logic [IW-1:0]        instr_q, instr_d;
    logic                 instr_valid_q, instr_valid_d;

    logic [MW-1:0]        mem [Depth];
    logic                 mem_we;
    logic [AddrWidth-1:0] mem_waddr;
    logic [IW-1:0]        mem_wdata;

    logic                 beat_acc, first_beat, fetch_acc, rd_in_range;
    logic [LCW-1:0]       lane_idx;
    logic [AddrWidth-1:0] wbase, wnext;
    logic [AddrWidth:0]   count_base;
    logic [IW-1:0]        asm_word;
    logic [MW-1:0]        rd_word;

    assign beat_acc = bus.load_valid && (state_q != CLEAR);

    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        wptr_d       = wptr_q;
        lane_cnt_d   = lane_cnt_q;
        buf_d        = buf_q;
        load_done_d  = load_done_q;
        load_count_d = load_count_q;
        mem_we       = 1'b0;
        mem_waddr    = wptr_q;
        mem_wdata    = '0;
        fetch_acc    = 1'b0;

        // A beat accepted in IDLE starts a fresh word at load_base; later beats continue the current one.
        first_beat = (state_q == IDLE);
        lane_idx   = first_beat ? '0 : lane_cnt_q;
        wbase      = first_beat ? bus.load_base : wptr_q;
        wnext      = (wbase >= LAST_ADDR) ? '0 : wbase + 1'b1;
        count_base = first_beat ? '0 : load_count_q;
        asm_word   = first_beat ? '0 : buf_q;
        asm_word[lane_idx*DataWidth +: DataWidth] = bus.load_data;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            IDLE, LOAD: begin
                if (beat_acc) begin
                    wptr_d       = wbase;
                    load_count_d = count_base;
                    load_done_d  = 1'b0;
                    if (lane_idx == LAST_LANE || bus.load_last) begin
                        mem_we       = ({1'b0, wbase} < DEPTH_W);
                        mem_waddr    = wbase;
                        mem_wdata    = asm_word;
                        wptr_d       = wnext;
                        load_count_d = count_base + 1'b1;
                        lane_cnt_d   = '0;
                        buf_d        = '0;
                    end else begin
                        buf_d      = asm_word;
                        lane_cnt_d = lane_idx + 1'b1;
                    end
                    if (bus.load_last) begin
                        load_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end else if (state_q == IDLE && bus.fetch_req) begin
                    fetch_acc = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        rd_in_range   = ({1'b0, bus.fetch_pc} < DEPTH_W);
        rd_word       = rd_in_range ? mem[bus.fetch_pc] : '0;
        instr_valid_d = fetch_acc;
        instr_d       = fetch_acc ? rd_word[IW-1:0] : instr_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
`ifdef INSTR_MEM_PARITY_EN
            mem[mem_waddr] <= {(^mem_wdata) ^ bus.perr_inject, mem_wdata};
`else
            mem[mem_waddr] <= mem_wdata;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= CLEAR;
            clr_ptr_q     <= '0;
            wptr_q        <= '0;
            lane_cnt_q    <= '0;
            buf_q         <= '0;
            load_done_q   <= 1'b0;
            load_count_q  <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            wptr_q        <= wptr_d;
            lane_cnt_q    <= lane_cnt_d;
            buf_q         <= buf_d;
            load_done_q   <= load_done_d;
            load_count_q  <= load_count_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= fetch_acc && rd_in_range && (rd_word[IW] != ^rd_word[IW-1:0]);
        end
    end

    assign bus.parity_err = parity_err_q;
`endif

    assign bus.load_ready  = (state_q != CLEAR);
    assign bus.busy        = (state_q != IDLE);
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.load_done   = load_done_q;
    assign bus.load_count  = load_count_q;
endmodule
